deserializer: RTL
=================

# deserializer

Serial-to-parallel stage that sits directly downstream of the serializer and consumes its ser_data_o / ser_data_val_o stream. Bits arrive MSB first. They are packed left-aligned into a DATA_BUS_WIDTH word, which is emitted with a bit count in the serializer's data_mod encoding, so a loopback pair reproduces the original data_i / data_mod_i. A frame ends either on the W-th bit or when the valid input drops.

## Interface
- DATA_BUS_WIDTH, default 16: parallel word width W; must be at least 4.
- DATA_MOD_WIDTH, default $clog2(DATA_BUS_WIDTH): width of the bit-count field; 0 encodes a full W-bit word.
- clk_i  input  1: single clock; all logic on posedge.
- srst_i  input  1: reset, asynchronous, active-high.
- ser_data_i  input  1: serial data bit, sampled only when ser_data_val_i=1.
- ser_data_val_i  input  1: serial bit valid.
- deser_data_o  output  DATA_BUS_WIDTH: received word, left-aligned (first bit in [W-1]), unused low bits 0.
- deser_data_mod_o  output  DATA_MOD_WIDTH: number of valid bits; 0 means all W bits.
- deser_data_val_o  output  1: one-cycle pulse qualifying deser_data_o / deser_data_mod_o.
- frame_err_o  output  1: one-cycle pulse when a 1- or 2-bit frame is discarded.

## Operation
- States:
  - IDLE_S: no bits held.
  - RECV_S: 1..W-1 bits of the current word held.
- Internal registers:
  - bit counter cnt (DATA_MOD_WIDTH bits): number of bits held.
  - word buffer buf (W bits), cleared whenever a word starts.
- IDLE_S with val=1: write bit to buf[W-1], set cnt=1, go to RECV_S.
- IDLE_S with val=0: remain in IDLE_S.
- RECV_S with val=1 and cnt<W-1: write bit to buf[W-1-cnt], cnt+1.
- RECV_S with val=1 and cnt==W-1 (the W-th bit):
  - Register outputs: deser_data_o = buf with the bit in [0]; deser_data_mod_o = 0; deser_data_val_o = 1.
  - Clear buf and cnt; go to IDLE_S.
- RECV_S with val=0 (gap), cnt≥3:
  - Register outputs: deser_data_o = buf; deser_data_mod_o = cnt; deser_data_val_o = 1.
  - Go to IDLE_S.
- RECV_S with val=0, cnt in {1,2}:
  - Discard the bits; pulse frame_err_o; deser_data_val_o stays 0.
  - Go to IDLE_S.
- Frame boundaries:
  - A stream longer than W bits without a gap is split into consecutive words. Bit W+1 starts a new word from IDLE_S with no lost cycle.
  - A frame of exactly W bits emits once, on the W-th bit. The following gap cycle emits nothing, because the block is already in IDLE_S.
- Outputs hold their last value between pulses; only the val/err pulses return to 0.
- ser_data_i is ignored whenever ser_data_val_i=0.

## Timing
- Reset: while srst_i=1, state=IDLE_S, cnt=0, buf=0, deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, frame_err_o=0. Effect is immediate, with no clock edge needed.
- Reset mid-frame drops the partial word silently: no val and no err pulse. The first valid bit after release starts a fresh word.
- Latency, full word: deser_data_val_o is high in the cycle after the cycle in which the W-th bit is sampled.
- Latency, partial word: if g is the first cycle with val=0, deser_data_val_o (or frame_err_o) is high in cycle g+1.
- Throughput: 1 bit/cycle sustained. Continuous valid produces one word every W cycles.
- Serializer compatibility: the serializer always leaves at least one idle cycle between frames. Every serializer frame therefore produces exactly one output pulse.
- deser_data_val_o and frame_err_o are never high in the same cycle.

## Test plan
- Full word, W=16: 0xA5C3 sent MSB first over 16 consecutive valid cycles, then a gap -> one pulse in cycle 17 with deser_data_o=0xA5C3 and mod=0; no pulse on the gap.
- Partial word: bits 1,0,1,1,0 then a gap -> deser_data_o=0xB000, deser_data_mod_o=5, pulse one cycle after the first gap cycle.
- Short frames: a 2-bit frame 1,1 then a gap -> frame_err_o=1 for one cycle, deser_data_val_o stays 0. A 3-bit frame 1,1,1 -> 0xE000 with mod=3.
- Back-to-back: 32 continuous valid bits 0x1234 then 0xFFFF -> two pulses exactly 16 cycles apart with those values. Bits sampled while val=0 are ignored (toggle ser_data_i during gaps).
- Reset: assert srst_i asynchronously, between clock edges, after 7 bits -> outputs are 0 immediately, with no pulse. After release, a 16-bit 0x8001 frame decodes correctly.
- Loopback with the serializer for random data_i and data_mod_i in {0,3..15}: every frame returns deser_data_o = data_i masked to its top data_mod bits (full word for mod 0) and deser_data_mod_o = data_mod_i.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel stage: packs an MSB-first bit stream into left-aligned words with a bit count.
// A word ends on its W-th bit or when valid drops; one-cycle registered output pulse.
module deserializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      frame_err_o
);

  localparam logic IDLE_S = 1'b0;
  localparam logic RECV_S = 1'b1;

  localparam logic [DATA_MOD_WIDTH-1:0] LAST_CNT = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);
  localparam logic [DATA_MOD_WIDTH-1:0] MIN_CNT  = DATA_MOD_WIDTH'(3);

  logic                      state_q, state_d;
  logic [DATA_MOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic [DATA_MOD_WIDTH-1:0] mod_q, mod_d;
  logic                      val_q, val_d;
  logic                      err_q, err_d;
  logic [DATA_MOD_WIDTH-1:0] pos;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    pos     = LAST_CNT - cnt_q;

    case (state_q)
      IDLE_S: begin
        if (ser_data_val_i) begin
          buf_d                   = '0;
          buf_d[DATA_BUS_WIDTH-1] = ser_data_i;
          cnt_d                   = DATA_MOD_WIDTH'(1);
          state_d                 = RECV_S;
        end
      end
      default: begin
        if (ser_data_val_i) begin
          if (cnt_q == LAST_CNT) begin
            data_d  = {buf_q[DATA_BUS_WIDTH-1:1], ser_data_i};
            mod_d   = '0;
            val_d   = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE_S;
          end else begin
            buf_d[pos] = ser_data_i;
            cnt_d      = cnt_q + DATA_MOD_WIDTH'(1);
          end
        end else begin
          // Gap closes the frame; 1- or 2-bit remnants are dropped as errors.
          if (cnt_q >= MIN_CNT) begin
            data_d = buf_q;
            mod_d  = cnt_q;
            val_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = IDLE_S;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign frame_err_o      = err_q;

endmodule
